// File: rtl/mem_writeback_pkg.sv
`default_nettype none
// ============================================================================
// mem_writeback_pkg : memOp encodings and constants shared by decode/EX/MEM
// Revision: 1.0
// ============================================================================
package mem_writeback_pkg;

  localparam logic [3:0] MEMOP_NONE = 4'd0;
  localparam logic [3:0] MEMOP_LB   = 4'd1;
  localparam logic [3:0] MEMOP_LBU  = 4'd2;
  localparam logic [3:0] MEMOP_LH   = 4'd3;
  localparam logic [3:0] MEMOP_LHU  = 4'd4;
  localparam logic [3:0] MEMOP_LW   = 4'd5;
  localparam logic [3:0] MEMOP_SB   = 4'd6;
  localparam logic [3:0] MEMOP_SH   = 4'd7;
  localparam logic [3:0] MEMOP_SW   = 4'd8;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] ZERO_WORD = 32'd0;
  localparam logic        ENABLE    = 1'b1;
  localparam logic        DISABLE   = 1'b0;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEMOP_LB) && (op <= MEMOP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEMOP_SB) && (op <= MEMOP_SW);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
    logic r;
    r = 1'b0;
    case (op)
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: r = off[0];
      MEMOP_LW, MEMOP_SW:            r = |off;
      default:                       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_writeback_load_align.sv
`default_nettype none
// ============================================================================
// load_align : selects the addressed byte/halfword lane and extends it
// Revision: 1.0
// ============================================================================
module load_align
  import mem_writeback_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [3:0]        mem_op,
  input  logic [1:0]        offset,
  input  logic [WORD_W-1:0] rdata,
  output logic [WORD_W-1:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (offset)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
  end

  assign w_half = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (mem_op)
      MEMOP_LB:  result = {{(WORD_W-8){w_byte[7]}}, w_byte};
      MEMOP_LBU: result = {{(WORD_W-8){1'b0}}, w_byte};
      MEMOP_LH:  result = {{(WORD_W-16){w_half[15]}}, w_half};
      MEMOP_LHU: result = {{(WORD_W-16){1'b0}}, w_half};
      default:   result = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_writeback.sv
`default_nettype none
// ============================================================================
// mem_writeback : MEM/WB stage - req/ack data-memory access, load extension,
//                 write-back register and MEM-stage forwarding
// Revision: 1.0
// ============================================================================
module mem_writeback
  import mem_writeback_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_writeEnable,
  input  logic [REG_AW-1:0] in_regDest,
  input  logic [WORD_W-1:0] in_result,
  input  logic [3:0]        in_memOp,
  input  logic [WORD_W-1:0] in_storeData,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              stall,
  output logic              misalign,
  output logic [REG_AW-1:0] fwd_dest,
  output logic [WORD_W-1:0] fwd_result,
  output logic              wb_writeEnable,
  output logic [REG_AW-1:0] wb_regDest,
  output logic [WORD_W-1:0] wb_result
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic              w_is_load;
  logic              w_is_mem;
  logic              w_misal;
  logic              w_start;
  logic              w_done;
  logic [3:0]        w_be;
  logic [WORD_W-1:0] w_wdata;
  logic [WORD_W-1:0] w_load_data;

  assign w_is_load = is_load(in_memOp);
  assign w_is_mem  = w_is_load | is_store(in_memOp);
  assign w_misal   = is_misaligned(in_memOp, in_result[1:0]);

  load_align #(.WORD_W(WORD_W)) u_load_align (
    .mem_op (in_memOp),
    .offset (in_result[1:0]),
    .rdata  (mem_rdata),
    .result (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_BUSY;
      default: if (mem_ack) w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    misalign = 1'b0;
    w_start  = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && w_is_mem) begin
          if (w_misal) begin
            misalign = 1'b1;
          end else begin
            w_start = 1'b1;
            stall   = 1'b1;
          end
        end
      end
      default: begin
        stall  = ~mem_ack;
        w_done = mem_ack;
      end
    endcase
  end

  // Lane placement for stores; loads request the whole word
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = in_storeData;
    case (in_memOp)
      MEMOP_SB: begin
        w_be    = 4'b0001 << in_result[1:0];
        w_wdata = {(WORD_W/8){in_storeData[7:0]}};
      end
      MEMOP_SH: begin
        w_be    = in_result[1] ? 4'b1100 : 4'b0011;
        w_wdata = {(WORD_W/16){in_storeData[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= ZERO_WORD;
      mem_be         <= 4'b0000;
      mem_wdata      <= ZERO_WORD;
      wb_writeEnable <= DISABLE;
      wb_regDest     <= REG_ZERO;
      wb_result      <= ZERO_WORD;
    end else begin
      if (w_start) begin
        mem_req   <= 1'b1;
        mem_we    <= ~w_is_load;
        mem_addr  <= {in_result[WORD_W-1:2], 2'b00};
        mem_be    <= w_be;
        mem_wdata <= w_wdata;
      end else if (w_done) begin
        mem_req <= 1'b0;
      end

      wb_writeEnable <= DISABLE;
      wb_regDest     <= REG_ZERO;
      wb_result      <= ZERO_WORD;
      if (w_done && w_is_load) begin
        wb_writeEnable <= ENABLE;
        wb_regDest     <= in_regDest;
        wb_result      <= w_load_data;
      end else if ((r_state == ST_IDLE) && in_valid && !w_is_mem) begin
        wb_writeEnable <= in_writeEnable;
        wb_regDest     <= in_regDest;
        wb_result      <= in_result;
      end
    end
  end

  // Loads forward only in their ack cycle, when the data actually exists
  always_comb begin
    fwd_dest   = REG_ZERO;
    fwd_result = ZERO_WORD;
    if (w_done && w_is_load) begin
      fwd_dest   = in_regDest;
      fwd_result = w_load_data;
    end else if (in_valid && in_writeEnable && !w_is_load) begin
      fwd_dest   = in_regDest;
      fwd_result = in_result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_writeback.sv
`default_nettype none
// ============================================================================
// tb_mem_writeback : vector table, corner sequences and random ops vs. model
// Revision: 1.0
// ============================================================================
module tb_mem_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_writeEnable;
  logic [4:0]  in_regDest;
  logic [31:0] in_result, in_storeData;
  logic [3:0]  in_memOp;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        stall, misalign;
  logic [4:0]  fwd_dest, wb_regDest;
  logic [31:0] fwd_result, wb_result;
  logic        wb_writeEnable;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] res;
    logic [4:0]  dest;
    logic        we;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          waits;
    logic        e_wbwe;
    logic [31:0] e_wbres;
    logic        e_mis;
    logic        e_req;
    logic        e_mwe;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t tbl[15];

  mem_writeback #(.WORD_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_writeEnable(in_writeEnable), .in_regDest(in_regDest),
    .in_result(in_result), .in_memOp(in_memOp), .in_storeData(in_storeData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .misalign(misalign), .fwd_dest(fwd_dest), .fwd_result(fwd_result),
    .wb_writeEnable(wb_writeEnable), .wb_regDest(wb_regDest), .wb_result(wb_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_is_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  // Reference model: expected behaviour from lane arithmetic on the encodings
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int unsigned o, b, h, sb, sh;
    r = v;
    r.e_wbwe = 0; r.e_wbres = 0; r.e_mis = 0; r.e_req = 0;
    r.e_mwe = 0; r.e_be = 0; r.e_wdata = 0;
    o  = v.res % 4;
    b  = (v.rdata >> (8 * o)) % 256;
    h  = (v.rdata >> (16 * (o / 2))) % 65536;
    sb = v.sdata % 256;
    sh = v.sdata % 65536;
    case (v.op)
      4'd1: begin r.e_req = 1; r.e_wbwe = 1; r.e_wbres = (b >= 128) ? b - 256 : b; end
      4'd2: begin r.e_req = 1; r.e_wbwe = 1; r.e_wbres = b; end
      4'd3: if (o % 2 != 0) r.e_mis = 1;
            else begin r.e_req = 1; r.e_wbwe = 1; r.e_wbres = (h >= 32768) ? h - 65536 : h; end
      4'd4: if (o % 2 != 0) r.e_mis = 1;
            else begin r.e_req = 1; r.e_wbwe = 1; r.e_wbres = h; end
      4'd5: if (o != 0) r.e_mis = 1;
            else begin r.e_req = 1; r.e_wbwe = 1; r.e_wbres = v.rdata; end
      4'd6: begin r.e_req = 1; r.e_mwe = 1; r.e_be = 4'(1 << o); r.e_wdata = sb * 32'h01010101; end
      4'd7: if (o % 2 != 0) r.e_mis = 1;
            else begin
              r.e_req = 1; r.e_mwe = 1; r.e_be = (o >= 2) ? 4'hC : 4'h3;
              r.e_wdata = sh * 32'h00010001;
            end
      4'd8: if (o != 0) r.e_mis = 1;
            else begin r.e_req = 1; r.e_mwe = 1; r.e_be = 4'hF; r.e_wdata = v.sdata; end
      default: begin r.e_wbwe = v.we; r.e_wbres = v.res; end
    endcase
    return r;
  endfunction

  // Presents one instruction, plays the memory side, checks every observable
  task automatic run_vec(input vec_t v);
    int  nstall;
    int  waited;
    bit  done;
    bit  full;
    logic [4:0]  pf_dest;
    logic [31:0] pf_res;
    @(posedge clk); #1;
    in_valid = 1; in_memOp = v.op; in_result = v.res; in_regDest = v.dest;
    in_writeEnable = v.we; in_storeData = v.sdata;
    pf_dest = (!m_is_load(v.op) && v.we) ? v.dest : 5'd0;
    pf_res  = (!m_is_load(v.op) && v.we) ? v.res  : 32'd0;
    full    = v.e_wbwe || (!v.e_req && !v.e_mis);
    nstall  = 0;
    @(negedge clk);
    chk("misalign", misalign, v.e_mis);
    chk("stall_present", stall, v.e_req);
    chk("fwd_dest_present", fwd_dest, pf_dest);
    chk("fwd_result_present", fwd_result, pf_res);
    if (stall) begin
      nstall = 1; waited = 0; done = 0;
      for (int i = 0; i < 16 && !done; i++) begin
        @(posedge clk); #1;
        if (waited == v.waits) begin mem_ack = 1; mem_rdata = v.rdata; end
        else begin mem_ack = 0; mem_rdata = $urandom; end
        @(negedge clk);
        chk("mem_req_busy", mem_req, 1);
        chk("mem_addr", mem_addr, v.res & 32'hFFFFFFFC);
        chk("mem_we", mem_we, v.e_mwe);
        if (v.e_mwe) begin
          chk("mem_be", mem_be, v.e_be);
          chk("mem_wdata", mem_wdata, v.e_wdata);
        end
        chk("stall_busy", stall, (waited == v.waits) ? 0 : 1);
        if (waited == v.waits) begin
          if (m_is_load(v.op)) begin
            chk("fwd_dest_load", fwd_dest, v.dest);
            chk("fwd_result_load", fwd_result, v.e_wbres);
          end
          done = 1;
        end else begin
          nstall++; waited++;
        end
      end
      if (!done) chk("busy_timeout", 0, 1);
      chk("stall_cycles", nstall, 1 + v.waits);
    end
    @(posedge clk); #1;
    mem_ack = 0; in_valid = 0; in_memOp = 0;
    @(negedge clk);
    chk("wb_writeEnable", wb_writeEnable, v.e_wbwe);
    if (full) begin
      chk("wb_regDest", wb_regDest, v.dest);
      chk("wb_result", wb_result, v.e_wbres);
    end
    chk("mem_req_after", mem_req, 0);
    chk("stall_after", stall, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wb_one_cycle", wb_writeEnable, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst = 1; in_valid = 0; in_writeEnable = 0; in_regDest = 0; in_result = 0;
    in_memOp = 0; in_storeData = 0; mem_ack = 0; mem_rdata = 0;

    //        op     res            dest we sdata          rdata          w  wbwe wbres          mis req mwe be     wdata
    tbl[0]  = '{4'd0,  32'h00001234, 5'd3, 1, 32'h0,        32'h0,         0, 1, 32'h00001234, 0, 0, 0, 4'h0, 32'h0};
    tbl[1]  = '{4'd1,  32'h00000102, 5'd5, 1, 32'h0,        32'h00800000,  2, 1, 32'hFFFFFF80, 0, 1, 0, 4'h0, 32'h0};
    tbl[2]  = '{4'd2,  32'h00000102, 5'd5, 1, 32'h0,        32'h00800000,  2, 1, 32'h00000080, 0, 1, 0, 4'h0, 32'h0};
    tbl[3]  = '{4'd7,  32'h00000106, 5'd0, 0, 32'h0000BEEF, 32'h0,         1, 0, 32'h0,        0, 1, 1, 4'hC, 32'hBEEFBEEF};
    tbl[4]  = '{4'd5,  32'h00000101, 5'd6, 1, 32'h0,        32'h0,         0, 0, 32'h0,        1, 0, 0, 4'h0, 32'h0};
    tbl[5]  = '{4'd5,  32'h00000040, 5'd0, 1, 32'h0,        32'hFFFFFFFF,  0, 1, 32'hFFFFFFFF, 0, 1, 0, 4'h0, 32'h0};
    tbl[6]  = '{4'd3,  32'h00000102, 5'd8, 1, 32'h0,        32'h80011234,  1, 1, 32'hFFFF8001, 0, 1, 0, 4'h0, 32'h0};
    tbl[7]  = '{4'd4,  32'h00000100, 5'd8, 1, 32'h0,        32'h8001F234,  3, 1, 32'h0000F234, 0, 1, 0, 4'h0, 32'h0};
    tbl[8]  = '{4'd6,  32'h00000203, 5'd0, 0, 32'h123456AB, 32'h0,         0, 0, 32'h0,        0, 1, 1, 4'h8, 32'hABABABAB};
    tbl[9]  = '{4'd8,  32'h00000300, 5'd0, 0, 32'hCAFEF00D, 32'h0,         2, 0, 32'h0,        0, 1, 1, 4'hF, 32'hCAFEF00D};
    tbl[10] = '{4'd12, 32'h00000055, 5'd9, 1, 32'h0,        32'h0,         0, 1, 32'h00000055, 0, 0, 0, 4'h0, 32'h0};
    tbl[11] = '{4'd8,  32'h00000302, 5'd0, 0, 32'h00000001, 32'h0,         0, 0, 32'h0,        1, 0, 0, 4'h0, 32'h0};
    tbl[12] = '{4'd3,  32'h00000101, 5'd2, 1, 32'h0,        32'h0,         0, 0, 32'h0,        1, 0, 0, 4'h0, 32'h0};
    tbl[13] = '{4'd0,  32'h00000077, 5'd4, 0, 32'h0,        32'h0,         0, 0, 32'h00000077, 0, 0, 0, 4'h0, 32'h0};
    tbl[14] = '{4'd1,  32'h00000010, 5'd1, 0, 32'h0,        32'h000000FE,  0, 1, 32'hFFFFFFFE, 0, 1, 0, 4'h0, 32'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_wb_we", wb_writeEnable, 0);
    chk("rst_wb_dest", wb_regDest, 0);
    chk("rst_wb_result", wb_result, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_stall", stall, 0);
    @(posedge clk); #1;
    rst = 0;

    for (int i = 0; i < 15; i++) run_vec(tbl[i]);

    // Reset during BUSY, then a stray ack that must be ignored
    @(posedge clk); #1;
    in_valid = 1; in_memOp = 4'd5; in_result = 32'h200; in_regDest = 5'd7; in_writeEnable = 1;
    @(posedge clk); #1;
    rst = 1; in_valid = 0; in_memOp = 0;
    @(negedge clk);
    chk("rstbusy_req_before", mem_req, 1);
    @(posedge clk); #1;
    rst = 0; mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("rstbusy_req_dropped", mem_req, 0);
    chk("rstbusy_addr", mem_addr, 0);
    chk("rstbusy_stall", stall, 0);
    chk("rstbusy_fwd", fwd_dest, 0);
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
    chk("rstbusy_no_wb", wb_writeEnable, 0);
    chk("rstbusy_req_idle", mem_req, 0);

    // Ack while IDLE alongside an ALU op
    @(posedge clk); #1;
    in_valid = 1; in_memOp = 4'd0; in_result = 32'hABC; in_regDest = 5'd10; in_writeEnable = 1;
    mem_ack = 1;
    @(negedge clk);
    chk("idleack_stall", stall, 0);
    chk("idleack_fwd", fwd_dest, 10);
    @(posedge clk); #1;
    in_valid = 0; mem_ack = 0;
    @(negedge clk);
    chk("idleack_wb_we", wb_writeEnable, 1);
    chk("idleack_wb_res", wb_result, 32'hABC);
    chk("idleack_req", mem_req, 0);

    for (int i = 0; i < 150; i++) begin
      v.op    = 4'($urandom_range(0, 15));
      v.res   = $urandom;
      v.dest  = 5'($urandom_range(0, 31));
      v.we    = 1'($urandom_range(0, 1));
      v.sdata = $urandom;
      v.rdata = $urandom;
      v.waits = $urandom_range(0, 3);
      run_vec(model(v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
